// File: rtl/pmem.sv
// pmem: parametrised single-port synchronous memory with a built-in INIT
// sweep, command gating and a 1- or 2-cycle read pipeline.
//
// Ports:
//   clk      - single clock, rising edge
//   reset    - synchronous active-high reset; restarts the INIT sweep
//   clear    - request a new INIT sweep (accepted in INIT and IDLE)
//   read     - read command (IDLE only)
//   write    - write command (IDLE only)
//   addr     - command address
//   data_in  - write data
//   ready    - high while in IDLE; commands are accepted only then
//   data_out - read data, holds its last value between reads
//   rd_valid - one-cycle pulse when data_out carries new read data
//   conflict - one-cycle registered pulse for a read+write command
module pmem #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           ADDR_WIDTH = 5,
    parameter int unsigned           RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  conflict
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH:0]   cnt, cnt_next, cnt_inc;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic                  rd_go;
    logic                  conflict_set;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // The extra counter bit flags sweep completion without wrapping to 0.
    assign cnt_inc = cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_INIT: begin
                if (clear) begin
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt_inc;
                    if (cnt_inc[ADDR_WIDTH]) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (clear) begin
                    state_next = ST_INIT;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_INIT;
                cnt_next   = '0;
            end
        endcase
    end

    // Output / command decode
    always_comb begin
        ready        = (state == ST_IDLE);
        mem_we       = 1'b0;
        mem_wa       = addr;
        mem_wd       = data_in;
        rd_go        = 1'b0;
        conflict_set = 1'b0;
        if (!reset) begin
            if (state == ST_INIT) begin
                mem_we = 1'b1;
                mem_wa = cnt[ADDR_WIDTH-1:0];
                mem_wd = INIT_VALUE;
            end else if (!clear) begin
                if (read && write) begin
                    conflict_set = 1'b1;
                end else if (write) begin
                    mem_we = 1'b1;
                end else if (read) begin
                    rd_go = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict <= 1'b0;
        end else begin
            conflict <= conflict_set;
        end
    end

    // Read pipeline; clear does not touch it, so in-flight reads complete.
    if (RD_LATENCY == 1) begin : g_lat1
        always_ff @(posedge clk) begin
            if (reset) begin
                rd_valid <= 1'b0;
                data_out <= '0;
            end else begin
                rd_valid <= rd_go;
                if (rd_go) begin
                    data_out <= mem[addr];
                end
            end
        end
    end else begin : g_lat2
        logic                  s1_valid;
        logic [DATA_WIDTH-1:0] s1_data;

        always_ff @(posedge clk) begin
            if (reset) begin
                s1_valid <= 1'b0;
                rd_valid <= 1'b0;
                data_out <= '0;
            end else begin
                s1_valid <= rd_go;
                if (rd_go) begin
                    s1_data <= mem[addr];
                end
                rd_valid <= s1_valid;
                if (s1_valid) begin
                    data_out <= s1_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_pmem.sv
// tb_pmem: drives two pmem instances (RD_LATENCY 1 / INIT 0x00 and
// RD_LATENCY 2 / INIT 0x5A) with identical stimulus and checks both against
// a behavioural model through per-instance expected-read queues.
module tb_pmem;

    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       reset, clear, read, write;
    logic [4:0] addr;
    logic [7:0] data_in;

    logic       ready0, rv0, cf0;
    logic [7:0] dout0;
    logic       ready1, rv1, cf1;
    logic [7:0] dout1;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [7:0] mdl0[DEPTH];
    logic [7:0] mdl1[DEPTH];
    logic [7:0] last_dout[2];
    int         busy = DEPTH;
    int         cyc = 0;
    bit         exp_cf = 1'b0;
    bit         started = 1'b0;
    int         checks = 0;
    int         passes = 0;

    pmem #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(5),
        .RD_LATENCY(1),
        .INIT_VALUE(8'h00)
    ) u_lat1 (
        .clk(clk), .reset(reset), .clear(clear), .read(read), .write(write),
        .addr(addr), .data_in(data_in), .ready(ready0), .data_out(dout0),
        .rd_valid(rv0), .conflict(cf0)
    );

    pmem #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(5),
        .RD_LATENCY(2),
        .INIT_VALUE(8'h5A)
    ) u_lat2 (
        .clk(clk), .reset(reset), .clear(clear), .read(read), .write(write),
        .addr(addr), .data_in(data_in), .ready(ready1), .data_out(dout1),
        .rd_valid(rv1), .conflict(cf1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act === expv) begin
            passes++;
        end else begin
            $display("FAIL %s dut%0d cycle %0d: actual=%0h required=%0h",
                     nm, k, cyc, act, expv);
        end
    endtask

    task automatic fill_model();
        for (int i = 0; i < DEPTH; i++) begin
            mdl0[i] = 8'h00;
            mdl1[i] = 8'h5A;
        end
    endtask

    // One clock edge of stimulus; the model advances by the same edge.
    task automatic step(input bit rst, input bit clr, input bit rd, input bit wr,
                        input logic [4:0] a, input logic [7:0] d);
        reset   = rst;
        clear   = clr;
        read    = rd;
        write   = wr;
        addr    = a;
        data_in = d;
        @(posedge clk);
        cyc++;
        started = 1'b1;
        exp_cf  = 1'b0;
        if (rst) begin
            busy = DEPTH;
            fill_model();
            q0.delete();
            q1.delete();
            last_dout[0] = 8'h00;
            last_dout[1] = 8'h00;
        end else if (clr) begin
            busy = DEPTH;
            fill_model();
        end else if (busy > 0) begin
            busy--;
        end else if (rd && wr) begin
            exp_cf = 1'b1;
        end else if (wr) begin
            mdl0[a] = d;
            mdl1[a] = d;
        end else if (rd) begin
            q0.push_back('{data: mdl0[a], due: cyc});
            q1.push_back('{data: mdl1[a], due: cyc + 1});
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
    endtask

    task automatic mon(input int k, input logic rdy, input logic [7:0] dout,
                       input logic rv, input logic cf);
        exp_t e;
        bit   exp_rv;
        chk("ready", k, 32'(rdy), 32'(busy == 0));
        chk("conflict", k, 32'(cf), 32'(exp_cf));
        if (k == 0) exp_rv = (q0.size() > 0) && (q0[0].due == cyc);
        else        exp_rv = (q1.size() > 0) && (q1[0].due == cyc);
        chk("rd_valid", k, 32'(rv), 32'(exp_rv));
        if (exp_rv) begin
            if (k == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk("rd_data", k, 32'(dout), 32'(e.data));
            last_dout[k] = e.data;
        end else begin
            chk("dout_hold", k, 32'(dout), 32'(last_dout[k]));
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            mon(0, ready0, dout0, rv0, cf0);
            mon(1, ready1, dout1, rv1, cf1);
        end
    end

    initial begin
        reset   = 1'b1;
        clear   = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        addr    = '0;
        data_in = '0;
        last_dout[0] = 8'h00;
        last_dout[1] = 8'h00;
        fill_model();

        // Reset and the power-up sweep, then read every location.
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
        repeat (DEPTH + 1) idle();
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 5'(i), 8'd0);
        repeat (3) idle();

        // Data = address, back-to-back writes then reads.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 5'(i), 8'(i));
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 5'(i), 8'd0);
        repeat (3) idle();

        // Read+write conflict leaves addr 5 untouched.
        step(1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 8'hAA);
        idle();
        step(1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 8'd0);
        repeat (3) idle();

        // Read-after-write to the same address on the next cycle.
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 8'hC3);
        step(1'b0, 1'b0, 1'b1, 1'b0, 5'd12, 8'd0);
        repeat (3) idle();

        // Randomised traffic including clears, commands during INIT and resets.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 59) == 0),
                 1'($urandom), 1'($urandom), 5'($urandom), 8'($urandom));
        end
        for (int n = 0; n < DEPTH + 2 && busy > 0; n++) idle();

        // Clear together with a write: the write is dropped, no conflict.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 5'(i), 8'(i));
        step(1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 8'h33);
        for (int n = 0; n < DEPTH; n++) begin
            step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 5'($urandom), 8'($urandom));
        end
        idle();
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 5'(i), 8'd0);
        repeat (3) idle();

        // Read in flight when a clear is accepted returns pre-clear data.
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 8'd7);
        step(1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 8'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
        for (int n = 0; n < DEPTH; n++) begin
            step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 5'($urandom), 8'($urandom));
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 8'd0);
        repeat (3) idle();

        // Reset on the edge right after a read is accepted.
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 8'h99);
        step(1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 8'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
        repeat (DEPTH + 1) idle();
        step(1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 8'd0);
        repeat (4) idle();

        chk("q_empty", 0, 32'(q0.size()), 32'd0);
        chk("q_empty", 1, 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pmem.md
# pmem

Parametrised single-port synchronous memory with a built-in clear sequencer, command gating and a configurable read pipeline. It replaces the fixed 32x8 memory in the memory test environment. A hardware INIT sweep, rather than the bench, writes every location after reset or on request. Reads return data with a `rd_valid` strobe after a fixed latency. Illegal simultaneous read/write commands are flagged rather than silently dropped.

## Interface
- `DATA_WIDTH`, default 8: word width in bits, 1..64.
- `ADDR_WIDTH`, default 5: address width; DEPTH = 2**ADDR_WIDTH locations.
- `RD_LATENCY`, default 1: cycles from accepted read to `rd_valid`; legal values are 1 or 2.
- `INIT_VALUE`, default 0: DATA_WIDTH-bit value written to every location by the INIT sweep.
- `clk` in, 1: single clock; all logic is on the rising edge.
- `reset` in, 1: synchronous, active-high reset.
- `clear` in, 1: request a new INIT sweep.
- `read` in, 1: read command.
- `write` in, 1: write command.
- `addr` in, ADDR_WIDTH: command address.
- `data_in` in, DATA_WIDTH: write data.
- `ready` out, 1: commands are accepted only in cycles where this is high.
- `data_out` out, DATA_WIDTH: read data; holds its last value between reads.
- `rd_valid` out, 1: one-cycle pulse marking that `data_out` carries new read data.
- `conflict` out, 1: one-cycle pulse, registered, for an illegal read+write command.

## Operation
- FSM states are INIT and IDLE.
  - `reset` forces INIT with the sweep counter at 0.
  - In INIT, each cycle writes INIT_VALUE to location `cnt`, then increments `cnt`.
  - After the write to DEPTH-1, the FSM moves to IDLE.
  - `ready` = (state == IDLE), registered.
- IDLE command decode, in priority order:
  1. `clear` = 1: go to INIT with `cnt` = 0. Any read/write in the same cycle is discarded and `conflict` stays 0.
  2. `read` & `write` both 1: perform neither access and pulse `conflict` on the next cycle.
  3. `write` alone: mem[addr] <= data_in.
  4. `read` alone: launch a read of mem[addr] into the read pipeline.
- In INIT, `read`, `write` and `clear` are ignored, except that `clear` restarts the sweep with `cnt` = 0. `conflict` is never raised in INIT.
- Reads already launched when a `clear` is accepted complete normally and return pre-clear data.
- Accepted commands need no hold time: one command per cycle, and back-to-back reads and writes are legal every cycle.
- Read-after-write to the same address in the next cycle returns the new data. There is no same-cycle read-during-write, because rule 2 forbids it.
- Addresses are always in range, since DEPTH = 2**ADDR_WIDTH. The sweep counter is ADDR_WIDTH+1 bits wide so it can detect completion without wrapping.

## Timing
- Reset values: `ready` = 0, `data_out` = 0, `rd_valid` = 0, `conflict` = 0. The read pipeline is flushed and the FSM is in INIT. Memory contents are undefined until the sweep completes.
- Sweep timing, taking edge E0 as the first rising edge with `reset` = 0:
  - edges E0..E(DEPTH-1) write addresses 0..DEPTH-1;
  - `ready` rises after E(DEPTH-1), so it is high in cycle DEPTH.
  - A sweep therefore costs DEPTH cycles.
- `clear` sampled high at edge Ec drops `ready` after Ec. The sweep writes at Ec+1..Ec+DEPTH, and `ready` is high again after Ec+DEPTH.
- Read latency, for a read accepted at edge Er:
  - RD_LATENCY = 1: `data_out`/`rd_valid` update at Er.
  - RD_LATENCY = 2: they update at Er+1.
  - `rd_valid` is high for exactly one cycle per accepted read. Consecutive reads give consecutive pulses.
- `conflict` is high for the one cycle after the offending edge.
- `reset` mid-operation:
  - in-flight reads are discarded and produce no `rd_valid`;
  - `data_out` is forced to 0;
  - a new sweep starts.

## Test plan
- Reset, then wait: `ready` = 0 for 32 cycles, then 1. Reading all 32 addresses returns 0x00, and there are exactly 32 `rd_valid` pulses.
- Data = address: write i to addr i for i = 0..31 back-to-back, then read 0..31 back-to-back. Expect `data_out` = i, with latency 1 and 2 in separate runs (RD_LATENCY = 1/2).
- Conflict: in IDLE drive `read` = `write` = 1, addr 5, data 0xAA. Expect a one-cycle `conflict` pulse, no `rd_valid`, and a later read of addr 5 still returning its old value.
- Clear: after the data = address pass, pulse `clear` together with `write` to addr 3. Expect `ready` low for 32 cycles, no `conflict`, and all locations reading INIT_VALUE afterwards (run with INIT_VALUE = 0x5A).
- In-flight read across clear: read addr 7 (value 7) at the same edge as the cycle before `clear`. Expect `rd_valid` with 7 after the clear is accepted. Commands issued while `ready` = 0 are ignored.
- Mid-operation reset: assert `reset` on the edge right after a read is accepted, with RD_LATENCY = 2. Expect no `rd_valid`, `data_out` = 0, and `ready` returning only after a full 32-cycle sweep.
